// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter. The ALU has fixed priority on the single
// write port. LSU results that lose arbitration wait in an in-order buffer.
// A busy scoreboard tracks registers that have an outstanding load, so issue
// logic can stall readers of those registers.
module regfile_wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            mark_valid,
    input  logic [AW-1:0]   mark_rd,
    input  logic [AW-1:0]   chk_ra1,
    input  logic [AW-1:0]   chk_ra2,
    output logic            busy1,
    output logic            busy2,
    output logic            rf_we,
    output logic [AW-1:0]   rf_wa,
    output logic [XLEN-1:0] rf_wd
);

    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NREG = 2 ** AW;
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [AW-1:0]   buf_rd   [DEPTH];
    logic [XLEN-1:0] buf_data [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [PW:0]     count;

    // Marks that the write currently on rf_* came from the LSU, so its busy
    // bit is cleared at the following edge.
    logic            rf_lsu;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;

    logic full, empty, alu_win, lsu_acc, sel_buf, sel_byp, enq, deq;

    // Arbitration and buffer handshake decode.
    always_comb begin
        full      = (count == FULL_CNT);
        empty     = (count == '0);
        lsu_ready = !full && !rst;
        alu_win   = alu_valid && (alu_rd != '0);
        lsu_acc   = lsu_valid && lsu_ready;
        sel_buf   = !alu_win && !empty;
        // Bypass only when nothing is queued; an r0 result is accepted and dropped.
        sel_byp   = !alu_win && empty && lsu_acc && (lsu_rd != '0);
        enq       = lsu_acc && (lsu_rd != '0) && (alu_win || !empty);
        deq       = sel_buf;
    end

    // Buffer pointers and occupancy; pointers wrap because DEPTH is a power of 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + PW'(1);
            if (deq) head <= head + PW'(1);
            case ({enq, deq})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Buffer payload storage; contents are don't-care while the entry is invalid.
    always_ff @(posedge clk) begin
        if (enq) begin
            buf_rd[tail]   <= lsu_rd;
            buf_data[tail] <= lsu_data;
        end
    end

    // Registered write port: ALU, then buffer head, then LSU bypass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we  <= 1'b0;
            rf_wa  <= '0;
            rf_wd  <= '0;
            rf_lsu <= 1'b0;
        end else if (alu_win) begin
            rf_we  <= 1'b1;
            rf_wa  <= alu_rd;
            rf_wd  <= alu_data;
            rf_lsu <= 1'b0;
        end else if (sel_buf) begin
            rf_we  <= 1'b1;
            rf_wa  <= buf_rd[head];
            rf_wd  <= buf_data[head];
            rf_lsu <= 1'b1;
        end else if (sel_byp) begin
            rf_we  <= 1'b1;
            rf_wa  <= lsu_rd;
            rf_wd  <= lsu_data;
            rf_lsu <= 1'b1;
        end else begin
            rf_we  <= 1'b0;
            rf_lsu <= 1'b0;
        end
    end

    // Scoreboard next state: clear after an LSU commit, then set (set wins).
    always_comb begin
        busy_nxt = busy;
        if (rf_we && rf_lsu) busy_nxt[rf_wa] = 1'b0;
        if (mark_valid && (mark_rd != '0)) busy_nxt[mark_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else     busy <= busy_nxt;
    end

    // Combinational scoreboard queries.
    always_comb begin
        busy1 = busy[chk_ra1];
        busy2 = busy[chk_ra2];
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a queue-based reference model
// predicts each cycle's write-port contents; a monitor compares on negedge.
module tb_regfile_wb_arbiter;

    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            alu_valid = 1'b0;
    logic [AW-1:0]   alu_rd = '0;
    logic [XLEN-1:0] alu_data = '0;
    logic            lsu_valid = 1'b0;
    logic            lsu_ready;
    logic [AW-1:0]   lsu_rd = '0;
    logic [XLEN-1:0] lsu_data = '0;
    logic            mark_valid = 1'b0;
    logic [AW-1:0]   mark_rd = '0;
    logic [AW-1:0]   chk_ra1 = '0;
    logic [AW-1:0]   chk_ra2 = '0;
    logic            busy1, busy2;
    logic            rf_we;
    logic [AW-1:0]   rf_wa;
    logic [XLEN-1:0] rf_wd;

    regfile_wb_arbiter #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .mark_valid(mark_valid), .mark_rd(mark_rd),
        .chk_ra1(chk_ra1), .chk_ra2(chk_ra2), .busy1(busy1), .busy2(busy2),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } ent_t;

    typedef struct packed {
        logic            we;
        logic [AW-1:0]   wa;
        logic [XLEN-1:0] wd;
    } exp_t;

    // Reference model state
    ent_t            lq[$];
    exp_t            exp_q[$];
    bit              busy_m [2**AW];
    bit              clr_v;
    logic [AW-1:0]   clr_rd;
    logic [AW-1:0]   last_wa;
    logic [XLEN-1:0] last_wd;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
    endtask

    task automatic model_reset();
        lq.delete();
        for (int i = 0; i < 2**AW; i++) busy_m[i] = 1'b0;
        clr_v   = 1'b0;
        clr_rd  = '0;
        last_wa = '0;
        last_wd = '0;
    endtask

    task automatic drive_idle();
        alu_valid = 0; alu_rd = '0; alu_data = '0;
        lsu_valid = 0; lsu_rd = '0; lsu_data = '0;
        mark_valid = 0; mark_rd = '0;
    endtask

    // One reset cycle; reset takes effect asynchronously mid-cycle.
    task automatic reset_cycle();
        @(negedge clk); #1;
        rst = 1'b1;
        drive_idle();
        #1;
        chk("rst_we_immediate", rf_we, 1'b0);
        chk("rst_lsu_ready", lsu_ready, 1'b0);
        model_reset();
        exp_q.push_back('{we: 1'b0, wa: '0, wd: '0});
    endtask

    // One functional cycle: drive inputs, check combinational outputs, and
    // predict what the write port shows after the coming edge.
    task automatic cycle(input logic av, input logic [AW-1:0] ard, input logic [XLEN-1:0] ad,
                         input logic lv, input logic [AW-1:0] lrd, input logic [XLEN-1:0] ld,
                         input logic mv, input logic [AW-1:0] mrd,
                         input logic [AW-1:0] c1, input logic [AW-1:0] c2);
        ent_t w;
        bit   have_w, w_lsu, bypass, ready_m, acc;
        @(negedge clk); #1;
        rst = 1'b0;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        mark_valid = mv; mark_rd = mrd;
        chk_ra1 = c1; chk_ra2 = c2;
        #1;
        ready_m = (lq.size() < DEPTH);
        chk("lsu_ready", lsu_ready, ready_m);
        chk("busy1", busy1, busy_m[c1]);
        chk("busy2", busy2, busy_m[c2]);
        acc    = lv && ready_m;
        w      = '{rd: '0, data: '0};
        have_w = 0; w_lsu = 0; bypass = 0;
        if (av && ard != 0) begin
            have_w = 1; w.rd = ard; w.data = ad;
        end else if (lq.size() > 0) begin
            have_w = 1; w_lsu = 1; w = lq.pop_front();
        end else if (acc && lrd != 0) begin
            have_w = 1; w_lsu = 1; bypass = 1; w.rd = lrd; w.data = ld;
        end
        if (acc && lrd != 0 && !bypass) lq.push_back('{rd: lrd, data: ld});
        if (clr_v) busy_m[clr_rd] = 1'b0;
        if (mv && mrd != 0) busy_m[mrd] = 1'b1;
        clr_v  = w_lsu;
        clr_rd = w.rd;
        if (have_w) begin
            last_wa = w.rd;
            last_wd = w.data;
        end
        exp_q.push_back('{we: have_w, wa: last_wa, wd: last_wd});
    endtask

    task automatic idle(input logic [AW-1:0] c1, input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, c1, 0);
    endtask

    // Monitor: compares the registered write port against the prediction.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rf_we", rf_we, e.we);
                chk("rf_wa", rf_wa, e.wa);
                chk("rf_wd", rf_wd, e.wd);
            end
        end
    end

    initial begin : stimulus
        model_reset();
        reset_cycle();
        reset_cycle();
        idle(0, 2);

        // Single ALU write, then nothing.
        cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0);
        idle(5, 2);

        // Same-cycle collision with a marked load destination.
        cycle(0, 0, 0, 0, 0, 0, 1, 7, 7, 3);
        cycle(1, 3, 32'h0000_0033, 1, 7, 32'h11, 0, 0, 7, 3);
        idle(7, 4);

        // ALU streak while LSU offers r1..r3; r3 is held until accepted.
        cycle(0, 0, 0, 0, 0, 0, 1, 1, 1, 2);
        cycle(0, 0, 0, 0, 0, 0, 1, 2, 1, 2);
        cycle(0, 0, 0, 0, 0, 0, 1, 3, 3, 2);
        cycle(1, 10, 32'hA0, 1, 1, 32'h101, 0, 0, 1, 3);
        cycle(1, 11, 32'hA1, 1, 2, 32'h102, 0, 0, 2, 3);
        cycle(1, 12, 32'hA2, 1, 3, 32'h103, 0, 0, 1, 3);
        cycle(1, 13, 32'hA3, 1, 3, 32'h103, 0, 0, 2, 3);
        cycle(0, 0, 0, 1, 3, 32'h103, 0, 0, 1, 3);
        cycle(0, 0, 0, 1, 3, 32'h103, 0, 0, 2, 3);
        idle(3, 4);

        // Register 0 from both sources, and marking r0.
        cycle(1, 0, 32'h55, 1, 0, 32'h66, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 32'h77, 1, 0, 0, 0);
        idle(0, 2);

        // Re-mark r9 at the edge its LSU commit would clear it.
        cycle(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
        cycle(0, 0, 0, 1, 9, 32'h99, 0, 0, 9, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
        idle(9, 3);

        // Reset while two LSU results are buffered.
        cycle(0, 0, 0, 0, 0, 0, 1, 4, 4, 6);
        cycle(0, 0, 0, 0, 0, 0, 1, 6, 4, 6);
        cycle(1, 20, 32'hB0, 1, 4, 32'h44, 0, 0, 4, 6);
        cycle(1, 21, 32'hB1, 1, 6, 32'h66, 0, 0, 4, 6);
        reset_cycle();
        reset_cycle();
        idle(4, 4);

        // Randomized traffic; LSU holds its offer until accepted.
        begin
            logic            lv_h;
            logic [AW-1:0]   lrd_h;
            logic [XLEN-1:0] ld_h;
            bit              rdy_before;
            lv_h = 0; lrd_h = '0; ld_h = '0;
            for (int i = 0; i < 500; i++) begin
                if (!lv_h && $urandom_range(0, 99) < 55) begin
                    lv_h  = 1;
                    lrd_h = AW'($urandom_range(0, 7));
                    ld_h  = $urandom;
                end
                rdy_before = (lq.size() < DEPTH);
                cycle($urandom_range(0, 99) < 45, AW'($urandom_range(0, 7)), $urandom,
                      lv_h, lrd_h, ld_h,
                      $urandom_range(0, 99) < 30, AW'($urandom_range(0, 7)),
                      AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
                if (lv_h && rdy_before) lv_h = 0;
                if (i == 250) begin
                    reset_cycle();
                    lv_h = 0;
                end
            end
        end
        idle(0, 4);

        @(negedge clk); #1;
        chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
